alu_req_arbiter: RTL

- Shares one combinational ALU (add/sub/mul/logic/shift/compare/FP add-sub, 5-bit ALUControl, 64-bit result, V/C/Z/N flags) among NREQ requesters (CORDIC iteration engine, scalar core, debug port).
- Round-robin arbitration; latches the winner's operands and holds them stable on the ALU inputs for ALU_LAT cycles.
- Captures the result and flags, then returns them with a requester tag over a valid/ready response channel.
- Rejects unsupported opcodes without occupying the ALU.

---
 rtl/alu_req_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one combinational ALU among NREQ requesters with a valid/ready response channel
module alu_req_arbiter #(
  parameter int NREQ = 4,
  parameter int ALU_LAT = 1,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [5*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic [4:0]           alu_ctrl,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  input  logic [63:0]          alu_result,
  input  logic [3:0]           alu_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [63:0]          rsp_result,
  output logic [3:0]           rsp_flags,
  output logic                 rsp_err
);
  localparam int CW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [IDW-1:0] ptr, win;
  logic [CW-1:0] cnt;
  logic [4:0] op;
  logic any, legal;
  // downward scan so the lowest offset from ptr wins
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NREQ]) begin
        win = IDW'((int'(ptr) + k) % NREQ);
        any = 1'b1;
      end
  end
  assign op = req_op[5*win +: 5];
  assign legal = op <= 5'h0E || op == 5'h10 || op == 5'h11;
  assign gnt = (state == IDLE && any) ? (NREQ'(1) << win) : '0;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      alu_ctrl <= '0;
      alu_a <= '0;
      alu_b <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_result <= '0;
      rsp_flags <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any) begin
          alu_ctrl <= op;
          alu_a <= req_a[32*win +: 32];
          alu_b <= req_b[32*win +: 32];
          rsp_id <= win;
          ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
          cnt <= '0;
          if (legal) state <= EXEC;
          else begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_result <= '0;
            rsp_flags <= '0;
          end
        end
        EXEC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ALU_LAT - 1)) begin
            rsp_result <= alu_result;
            rsp_flags <= alu_flags;
            rsp_err <= 1'b0;
            rsp_valid <= 1'b1;
            state <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
